regwb_arbiter: RTL and testbench
================================

Name: regwb_arbiter

Overview:
- Writer side of the register-file write port (wn/d/we, captured by the register file on negedge clk).
- Merges two producers onto that single port:
  - the in-order pipeline WB stage, which never stalls;
  - a long-latency unit (mul/div), whose results are buffered in a small FIFO.
- Keeps a per-register busy scoreboard so decode can stall RAW/WAW hazards against outstanding long-latency results.

Parameters:
- DEPTH, 4: long-latency result FIFO entries; power of two, >=2.
- DW, 32: data width.
- AW, 5: register address width; register count is 2**AW, r0 is hardwired zero.

Ports:
- clk  in  1  clock; all state updates on posedge.
- clr  in  1  asynchronous active-high reset.
- wb_we  in  1  pipeline writeback enable.
- wb_wn  in  AW  pipeline destination register.
- wb_d  in  DW  pipeline writeback data.
- lu_valid  in  1  long-latency result valid.
- lu_wn  in  AW  long-latency destination register.
- lu_d  in  DW  long-latency result data.
- lu_ready  out  1  FIFO can accept a result this cycle.
- iss_valid  in  1  decode issues a long-latency op; reserves iss_wn.
- iss_wn  in  AW  register to reserve.
- busy  out  2**AW  scoreboard; bit i = register i has an outstanding long-latency write.
- rf_we  out  1  register-file write enable (registered).
- rf_wn  out  AW  register-file write address (registered).
- rf_d  out  DW  register-file write data (registered).
- err  out  1  sticky protocol error; only meaningful with REGWB_CHECK_EN.

Behaviour:
- Interface: one clock clk; reset clr is asynchronous and active-high.
- Reset (clr=1): FIFO empty, busy=0, rf_we=0, rf_wn=0, rf_d=0, err=0, lu_ready=1 after release.
- Pipeline writes:
  - A pipeline write is effective when wb_we=1 and wb_wn!=0; wb_we=1 with wb_wn=0 is ignored and consumes no port slot.
  - A pipeline write has fixed latency: posedge N sample -> rf_* driven from N+1 -> register file captures at the following negedge.
- Long-latency handshake:
  - Transfer occurs on a posedge with lu_valid=1 and lu_ready=1.
  - lu_ready = (count < DEPTH), computed from the current count only; a full FIFO refuses even if it pops that same cycle.
  - lu_wn=0 results are accepted but discarded: no FIFO push, no busy effect.
- Port arbitration at each posedge:
  1. Effective pipeline write: rf_we=1, rf_wn=wb_wn, rf_d=wb_d; FIFO head is held.
  2. Otherwise, FIFO non-empty: pop the head into rf_* with rf_we=1.
  3. Otherwise rf_we=0; rf_wn and rf_d hold their previous values.
- FIFO timing and order:
  - Strict FIFO order.
  - A result pushed at edge N is poppable at edge N+1 at the earliest; there is no same-edge bypass from lu_* to rf_*.
  - Push and pop on the same edge: count unchanged, pointers wrap modulo DEPTH.
- Scoreboard:
  - iss_valid=1 with iss_wn!=0 sets busy[iss_wn] at the edge.
  - The FIFO pop that writes register k clears busy[k] at the same edge where rf_we rises for it.
  - Set and clear of the same register on the same edge: set wins (new reservation).
  - busy[0] is always 0.
- Ordering contract: decode never issues an op (pipeline or long-latency) whose destination or sources are busy. WAW between the pipeline and the FIFO is therefore excluded by construction; the block does not reorder.
- Starvation: continuous pipeline writes may hold the FIFO head indefinitely. This is accepted; the pipeline stalls on busy.
- Reset asserted mid-operation: all queued results are dropped, busy cleared, rf_we drops immediately (asynchronously).

Optional Feature:
- Macro REGWB_CHECK_EN. When defined, err is set (sticky until clr) on any of:
  - (a) a push with lu_wn!=0 whose busy[lu_wn]=0;
  - (b) iss_valid with iss_wn!=0 whose busy[iss_wn] is already 1;
  - (c) lu_valid=1 while lu_ready=0.
- When not defined, err is tied to 0 and the check logic is absent.

Decomposition:
- Package regwb_pkg:
  - AW/DW defaults;
  - NREG = 2**AW;
  - typedef wr_req_t {wn[AW], d[DW]} used for FIFO entries and the rf_* bundle.
- Sub-module regwb_fifo: synchronous FIFO of wr_req_t, DEPTH entries, with push/pop/full/empty/count and asynchronous active-high clear.
- Arbitration, scoreboard and checks stay in regwb_arbiter.

Test Plan:
- Reset check: assert clr mid-run with 3 queued entries -> rf_we=0 immediately; busy=0, lu_ready=1, FIFO empty after release.
- Basic long-latency write: iss r5; push lu_wn=5, d=0xDEADBEEF; wb_we=0 -> busy[5]=1 until the pop edge; rf_we=1, rf_wn=5, rf_d=0xDEADBEEF one cycle after the push; busy[5]=0 on that edge.
- Pipeline priority: queue r7=0x11 while wb_we=1 for 3 cycles (r1,r2,r3) -> rf_* shows r1, r2, r3, then r7=0x11; FIFO order preserved.
- Full FIFO: with wb_we held 1, push 4 entries -> lu_ready=0 at count 4; release wb_we -> 4 pops in order; lu_ready returns to 1 after the first pop.
- r0 handling: wb_we=1 with wb_wn=0 does not block a FIFO pop that cycle; lu_wn=0 push leaves count unchanged; iss_wn=0 leaves busy=0.
- Set/clear collision: pop of r9 on the same edge as iss r9 -> busy[9] remains 1. With REGWB_CHECK_EN, push to a non-busy r4 -> err=1 and it stays 1.

Source files
------------

// File: rtl/regwb_pkg.sv
// Shared defaults (address/data widths, register count) and the write-request
// bundle carried by the long-latency FIFO and the register-file port.
`timescale 1ns/1ps
package regwb_pkg;

    localparam int REGWB_AW = 5;
    localparam int REGWB_DW = 32;
    localparam int NREG     = 2 ** REGWB_AW;

    typedef struct packed {
        logic [REGWB_AW-1:0] wn;
        logic [REGWB_DW-1:0] d;
    } wr_req_t;

endpackage

// File: rtl/regwb_fifo.sv
// Result buffer for the long-latency unit: DEPTH-entry synchronous FIFO of
// wr_req_t with an asynchronous active-high clear. DEPTH must be a power of two.
`timescale 1ns/1ps
module regwb_fifo
    import regwb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          push,
    input  wr_req_t       push_data,
    input  logic          pop,
    output wr_req_t       head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    wr_req_t       mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not cleared: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/regwb_arbiter.sv
// Register-file write-port arbiter: pipeline WB has priority over buffered
// long-latency results; keeps the per-register busy scoreboard for decode.
// Optional protocol checker enabled by defining REGWB_CHECK_EN (err tied 0 otherwise).
// AW/DW must match the widths of regwb_pkg::wr_req_t.
`timescale 1ns/1ps
module regwb_arbiter
    import regwb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = REGWB_DW,
    parameter int AW    = REGWB_AW
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_wn,
    input  logic [DW-1:0]     wb_d,
    input  logic              lu_valid,
    input  logic [AW-1:0]     lu_wn,
    input  logic [DW-1:0]     lu_d,
    output logic              lu_ready,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_wn,
    output logic [2**AW-1:0]  busy,
    output logic              rf_we,
    output logic [AW-1:0]     rf_wn,
    output logic [DW-1:0]     rf_d,
    output logic              err
);

    localparam int NR = 2 ** AW;
    localparam int CW = $clog2(DEPTH + 1);

    wr_req_t       rf_req_q;
    wr_req_t       rf_req_d;
    logic          rf_we_q;
    logic          rf_we_d;
    logic [NR-1:0] busy_q;
    logic [NR-1:0] busy_d;

    wr_req_t       lu_req;
    wr_req_t       head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          wb_eff;
    logic          push;
    logic          pop;

    // A write to r0 is a no-op and must not take the port from the FIFO.
    assign wb_eff   = wb_we && (wb_wn != '0);
    assign lu_ready = (fifo_count < CW'(DEPTH));
    assign push     = lu_valid && !fifo_full && (lu_wn != '0);
    assign pop      = !wb_eff && !fifo_empty;
    assign lu_req   = '{wn: lu_wn, d: lu_d};

    regwb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .clr       (clr),
        .push      (push),
        .push_data (lu_req),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        rf_we_d  = 1'b0;
        rf_req_d = rf_req_q;
        busy_d   = busy_q;
        if (wb_eff) begin
            rf_we_d  = 1'b1;
            rf_req_d = '{wn: wb_wn, d: wb_d};
        end else if (pop) begin
            rf_we_d         = 1'b1;
            rf_req_d        = head;
            busy_d[head.wn] = 1'b0;
        end
        // A fresh reservation overrides the clear from a same-edge pop.
        if (iss_valid && (iss_wn != '0)) busy_d[iss_wn] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rf_we_q  <= 1'b0;
            rf_req_q <= '0;
            busy_q   <= '0;
        end else begin
            rf_we_q  <= rf_we_d;
            rf_req_q <= rf_req_d;
            busy_q   <= busy_d;
        end
    end

    assign rf_we = rf_we_q;
    assign rf_wn = rf_req_q.wn;
    assign rf_d  = rf_req_q.d;
    assign busy  = busy_q;

`ifdef REGWB_CHECK_EN
    logic err_q;
    logic err_d;

    always_comb begin
        err_d = err_q;
        if (lu_valid && lu_ready && (lu_wn != '0) && !busy_q[lu_wn]) err_d = 1'b1;
        if (iss_valid && (iss_wn != '0) && busy_q[iss_wn])            err_d = 1'b1;
        if (lu_valid && !lu_ready)                                    err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_regwb_arbiter.sv
// Scoreboard bench for regwb_arbiter: directed scenarios followed by random
// traffic, checked against a queue-based model of the write port.
`timescale 1ns/1ps
module tb_regwb_arbiter;
    import regwb_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = REGWB_AW;
    localparam int DW    = REGWB_DW;
    localparam int NR    = 2 ** AW;

    logic          clk = 1'b0;
    logic          clr;
    logic          wb_we;
    logic [AW-1:0] wb_wn;
    logic [DW-1:0] wb_d;
    logic          lu_valid;
    logic [AW-1:0] lu_wn;
    logic [DW-1:0] lu_d;
    logic          lu_ready;
    logic          iss_valid;
    logic [AW-1:0] iss_wn;
    logic [NR-1:0] busy;
    logic          rf_we;
    logic [AW-1:0] rf_wn;
    logic [DW-1:0] rf_d;
    logic          err;

    regwb_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .clr       (clr),
        .wb_we     (wb_we),
        .wb_wn     (wb_wn),
        .wb_d      (wb_d),
        .lu_valid  (lu_valid),
        .lu_wn     (lu_wn),
        .lu_d      (lu_d),
        .lu_ready  (lu_ready),
        .iss_valid (iss_valid),
        .iss_wn    (iss_wn),
        .busy      (busy),
        .rf_we     (rf_we),
        .rf_wn     (rf_wn),
        .rf_d      (rf_d),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: results waiting in the long-latency buffer, expected
    // register-file writes, reservations, and last value seen on rf_*.
    wr_req_t       m_fifo[$];
    wr_req_t       exp_q[$];
    logic [NR-1:0] m_busy;
    logic          m_err;
    wr_req_t       m_last;
    int            pending[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        pending.delete();
        m_busy = '0;
        m_err  = 1'b0;
        m_last = '0;
    endtask

    // Applies one cycle of inputs, advances the model across the coming edge,
    // then returns 1 ns after the following negedge.
    task automatic drive(input bit wwe, input int wwn, input logic [DW-1:0] wd,
                         input bit lv, input int lwn, input logic [DW-1:0] ld,
                         input bit iv, input int iwn);
        logic [AW-1:0] wn_c;
        logic [AW-1:0] lwn_c;
        logic [AW-1:0] iwn_c;
        bit            rdy;
        wr_req_t       e;
        wn_c  = AW'(wwn);
        lwn_c = AW'(lwn);
        iwn_c = AW'(iwn);
        wb_we = wwe; wb_wn = wn_c; wb_d = wd;
        lu_valid = lv; lu_wn = lwn_c; lu_d = ld;
        iss_valid = iv; iss_wn = iwn_c;

        rdy = (m_fifo.size() < DEPTH);
`ifdef REGWB_CHECK_EN
        if (lv && !rdy) m_err = 1'b1;
        if (lv && rdy && lwn_c != 0 && !m_busy[lwn_c]) m_err = 1'b1;
        if (iv && iwn_c != 0 && m_busy[iwn_c]) m_err = 1'b1;
`endif
        if (wwe && wn_c != 0) begin
            exp_q.push_back('{wn: wn_c, d: wd});
        end else if (m_fifo.size() != 0) begin
            e = m_fifo.pop_front();
            exp_q.push_back(e);
            m_busy[e.wn] = 1'b0;
        end
        if (lv && rdy && lwn_c != 0) m_fifo.push_back('{wn: lwn_c, d: ld});
        if (iv && iwn_c != 0) m_busy[iwn_c] = 1'b1;

        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, '0, 0, 0, '0, 0, 0);
    endtask

    // Monitor: compares the port, scoreboard and ready against the model.
    initial begin : monitor
        wr_req_t e;
        bit      has;
        forever begin
            @(negedge clk);
            if (clr === 1'b0) begin
                check("lu_ready", lu_ready, (m_fifo.size() < DEPTH));
                check("busy", busy, m_busy);
                check("err", err, m_err);
                has = (exp_q.size() != 0);
                check("rf_we", rf_we, has);
                if (has) begin
                    e = exp_q.pop_front();
                    check("rf_wn", rf_wn, e.wn);
                    check("rf_d", rf_d, e.d);
                    m_last = e;
                end else begin
                    check("rf_wn_hold", rf_wn, m_last.wn);
                    check("rf_d_hold", rf_d, m_last.d);
                end
            end
        end
    end

    initial begin : stim
        bit            wwe, lv, iv;
        int            wwn, lwn, iwn;
        logic [DW-1:0] wd, ld;

        clr = 1'b1;
        wb_we = 0; wb_wn = '0; wb_d = '0;
        lu_valid = 0; lu_wn = '0; lu_d = '0;
        iss_valid = 0; iss_wn = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_rf_we", rf_we, 0);
        check("rst_rf_wn", rf_wn, 0);
        check("rst_rf_d", rf_d, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        clr = 1'b0;
        check("rst_lu_ready", lu_ready, 1);

        // Basic long-latency write to r5
        drive(0, 0, '0, 0, 0, '0, 1, 5);
        check("basic_busy5_set", busy[5], 1);
        drive(0, 0, '0, 1, 5, 32'hDEADBEEF, 0, 0);
        check("basic_busy5_held", busy[5], 1);
        check("basic_no_bypass", rf_we, 0);
        idle(1);
        check("basic_rf_we", rf_we, 1);
        check("basic_rf_wn", rf_wn, 5);
        check("basic_rf_d", rf_d, 32'hDEADBEEF);
        check("basic_busy5_clr", busy[5], 0);

        // Pipeline priority: r1, r2, r3 then buffered r7
        drive(0, 0, '0, 0, 0, '0, 1, 7);
        drive(1, 1, 32'hA1, 1, 7, 32'h11, 0, 0);
        drive(1, 2, 32'hA2, 0, 0, '0, 0, 0);
        drive(1, 3, 32'hA3, 0, 0, '0, 0, 0);
        check("prio_r3_wn", rf_wn, 3);
        idle(1);
        check("prio_r7_wn", rf_wn, 7);
        check("prio_r7_d", rf_d, 32'h11);
        idle(1);

        // Full FIFO while the pipeline holds the port
        for (int i = 0; i < 4; i++) drive(1, 20, $urandom, 0, 0, '0, 1, 10 + i);
        for (int i = 0; i < 4; i++) drive(1, 20, $urandom, 1, 10 + i, 32'h100 + i, 0, 0);
        check("full_not_ready", lu_ready, 0);
        drive(1, 20, $urandom, 0, 0, '0, 0, 0);
        check("full_still_not_ready", lu_ready, 0);
        idle(1);
        check("full_ready_after_pop", lu_ready, 1);
        check("full_first_pop_wn", rf_wn, 10);
        idle(4);

        // r0 handling
        drive(0, 0, '0, 0, 0, '0, 1, 6);
        drive(1, 21, 32'h2121, 1, 6, 32'h66, 0, 0);
        drive(1, 0, 32'hBAD, 0, 0, '0, 0, 0);
        check("r0_wb_pop_we", rf_we, 1);
        check("r0_wb_pop_wn", rf_wn, 6);
        drive(0, 0, '0, 1, 0, 32'h77, 1, 0);
        check("r0_busy_none", busy, 0);
        idle(1);
        check("r0_no_write", rf_we, 0);

        // Set/clear collision on r9
        drive(0, 0, '0, 0, 0, '0, 1, 9);
        drive(0, 0, '0, 1, 9, 32'h99, 0, 0);
        drive(0, 0, '0, 0, 0, '0, 1, 9);
        check("coll_pop_wn", rf_wn, 9);
        check("coll_busy9", busy[9], 1);
        drive(0, 0, '0, 1, 9, 32'h9A, 0, 0);
        idle(1);
        check("coll_busy9_clr", busy[9], 0);

        // Mid-run reset with three queued results
        for (int i = 0; i < 3; i++) drive(1, 22, $urandom, 0, 0, '0, 1, 14 + i);
        for (int i = 0; i < 3; i++) drive(1, 22, $urandom, 1, 14 + i, $urandom, 0, 0);
        check("pre_reset_rf_we", rf_we, 1);
        #1 clr = 1'b1;
        #1 check("reset_rf_we_async", rf_we, 0);
        wb_we = 0; lu_valid = 0; iss_valid = 0;
        model_reset();
        @(negedge clk);
        #1 clr = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_lu_ready", lu_ready, 1);
        check("reset_err", err, 0);
        idle(2);
        check("reset_fifo_empty", rf_we, 0);

        // Push to a register that was never reserved
        drive(0, 0, '0, 1, 4, 32'h44, 0, 0);
        idle(3);
`ifdef REGWB_CHECK_EN
        check("err_sticky", err, 1);
`else
        check("err_tied_low", err, 0);
`endif

        // Random traffic honouring the decode contract
        for (int c = 0; c < 1500; c++) begin
            wwe = ($urandom_range(0, 1) == 1);
            wwn = $urandom_range(0, NR - 1);
            if (m_busy[wwn]) wwn = 0;
            wd  = $urandom;
            lv = 0; lwn = 0; ld = $urandom;
            if (m_fifo.size() < DEPTH) begin
                if (pending.size() != 0 && $urandom_range(0, 9) < 5) begin
                    lv  = 1;
                    lwn = pending.pop_front();
                end else if ($urandom_range(0, 19) == 0) begin
                    lv = 1;
                end
            end
            iv = 0; iwn = 0;
            if ($urandom_range(0, 9) < 3) begin
                iwn = $urandom_range(1, NR - 1);
                if (!m_busy[iwn]) begin
                    iv = 1;
                    pending.push_back(iwn);
                end else begin
                    iwn = 0;
                end
            end
            drive(wwe, wwn, wd, lv, lwn, ld, iv, iwn);
        end
        idle(8);
        check("drain_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
